wb_master_bridge: RTL and testbench

Parametrised single-clock bridge from the XT_HB slave side to a Wishbone (classic, single-transfer) master port. It accepts one read, write or read-modify-write request at a time from the XT_HB decoder and issues the matching Wishbone cycle. Relative to the previous bridge it adds:
- configurable data and address width
- byte-lane select (`wb_sel_o`) and byte-merged RMW
- `wb_err_i` termination and a bus timeout

It sits between the XT_HB address decoder and a Wishbone peripheral cluster, with both sides on one clock.

---
 rtl/wb_master_bridge_pkg.sv | 21 ++
 rtl/wb_lane_merge.sv | 19 +
 rtl/wb_master_bridge.sv | 145 ++++++++++++++
 tb/tb_wb_master_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_bridge_pkg.sv
// Shared types for the XT_HB to Wishbone bridge: FSM state encoding and the
// latched request record.
package wb_master_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } wb_state_e;

    typedef struct packed {
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rmw;
    } wb_req_t;

endpackage

// File: rtl/wb_lane_merge.sv
// Byte-lane merge for read-modify-write: strobed lanes take the write data,
// the rest keep the bytes that were read.
module wb_lane_merge #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   rd_data,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = rd_data;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (strb[i]) merged[i*8 +: 8] = wr_data[i*8 +: 8];
        end
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Single-transfer bridge from the XT_HB slave side to a classic Wishbone master
// port, with byte-merged RMW, err termination and a strobe timeout.
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                hb_ren,
    input  logic                hb_wen,
    input  logic [31:0]         hb_raddr,
    input  logic [31:0]         hb_waddr,
    input  logic [31:0]         hb_wdata,
    input  logic [3:0]          hb_wstrb,
    output logic [31:0]         rdata,
    output logic                done,
    output logic                err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    wb_state_e         state;
    wb_req_t           req;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] merged;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_hit;
    logic              bus_fail;
    logic              unused_req;

    wb_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .rd_data (rbuf),
        .wr_data (req.wdata[DATA_W-1:0]),
        .strb    (req.wstrb[SEL_W-1:0]),
        .merged  (merged)
    );

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        // An ack landing on the last allowed strobe cycle still completes normally.
        timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST) && !wb_ack_i;
        bus_fail    = wb_err_i || timeout_hit;
        // Address and data bits above the configured widths are dropped on purpose.
        unused_req  = ^req;
        case (state)
            ST_READ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = {SEL_W{1'b1}};
                wb_adr_o = req.raddr[ADDR_W-1:0];
            end
            ST_MERGE: wb_cyc_o = 1'b1;
            ST_WRITE: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = req.waddr[ADDR_W-1:0];
                wb_dat_o = req.wdata[DATA_W-1:0];
                wb_sel_o = req.rmw ? {SEL_W{1'b1}} : req.wstrb[SEL_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= ST_IDLE;
            req    <= '0;
            rbuf   <= '0;
            rdata  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            to_cnt <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            to_cnt <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (hb_ren) req.raddr <= hb_raddr;
                    if (hb_wen) begin
                        req.waddr <= hb_waddr;
                        req.wdata <= hb_wdata;
                        req.wstrb <= hb_wstrb;
                    end
                    req.rmw <= hb_ren && hb_wen;
                    if (hb_ren)      state <= ST_READ;
                    else if (hb_wen) state <= ST_WRITE;
                end
                ST_READ: begin
                    if (bus_fail) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else if (wb_ack_i) begin
                        rdata <= 32'(wb_dat_i);
                        rbuf  <= wb_dat_i;
                        done  <= !req.rmw;
                        state <= req.rmw ? ST_MERGE : ST_DONE;
                    end else begin
                        to_cnt <= (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
                    end
                end
                ST_MERGE: begin
                    req.wdata[DATA_W-1:0] <= merged;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (bus_fail) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else if (wb_ack_i) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        to_cnt <= (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: a 32-bit instance with TIMEOUT=4 and an 8-bit
// instance with the timeout disabled, driven by a scripted Wishbone slave.
module tb_wb_master_bridge;

    localparam int TO32 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] hb_raddr = '0, hb_waddr = '0, hb_wdata = '0;
    logic [3:0]  hb_wstrb = '0;
    logic        ren32 = 1'b0, wen32 = 1'b0, ren8 = 1'b0, wen8 = 1'b0;

    logic [31:0] rdata32, dat32;
    logic        done32, err32, cyc32, stb32, we32;
    logic [7:0]  adr32;
    logic [3:0]  sel32;
    logic [31:0] sdat32 = '0;
    logic        ack32 = 1'b0, serr32 = 1'b0;

    logic [31:0] rdata8;
    logic        done8, err8, cyc8, stb8, we8;
    logic [7:0]  adr8, dato8;
    logic [0:0]  sel8;
    logic [7:0]  sdat8 = '0;
    logic        ack8 = 1'b0, serr8 = 1'b0;

    wb_master_bridge #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(TO32)) u32 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .hb_ren(ren32), .hb_wen(wen32), .hb_raddr(hb_raddr), .hb_waddr(hb_waddr),
        .hb_wdata(hb_wdata), .hb_wstrb(hb_wstrb),
        .rdata(rdata32), .done(done32), .err(err32),
        .wb_cyc_o(cyc32), .wb_stb_o(stb32), .wb_we_o(we32), .wb_adr_o(adr32),
        .wb_dat_o(dat32), .wb_sel_o(sel32), .wb_dat_i(sdat32),
        .wb_ack_i(ack32), .wb_err_i(serr32)
    );

    wb_master_bridge #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(0)) u8 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .hb_ren(ren8), .hb_wen(wen8), .hb_raddr(hb_raddr), .hb_waddr(hb_waddr),
        .hb_wdata(hb_wdata), .hb_wstrb(hb_wstrb),
        .rdata(rdata8), .done(done8), .err(err8),
        .wb_cyc_o(cyc8), .wb_stb_o(stb8), .wb_we_o(we8), .wb_adr_o(adr8),
        .wb_dat_o(dato8), .wb_sel_o(sel8), .wb_dat_i(sdat8),
        .wb_ack_i(ack8), .wb_err_i(serr8)
    );

    typedef struct {
        logic        ren, wen;
        logic [31:0] ra, wa, wd;
        logic [3:0]  ws;
        logic [31:0] srd;
        int          wrd, wwr;
        logic        erd, ewr, aerr;
        int          exp_done;
        logic        exp_err;
        logic [31:0] exp_rdata, exp_wdat;
        logic [3:0]  exp_sel;
        int          exp_nwr, exp_nstb;
    } vec_t;

    int n_chk = 0, n_fail = 0;

    // Scripted slave for the 32-bit port: answers after a per-phase wait count.
    int          s_wrd = 0, s_wwr = 0;
    logic        s_erd = 1'b0, s_ewr = 1'b0, s_aerr = 1'b0;
    int          scnt = 0, n_stb = 0, n_wr = 0;
    logic [7:0]  w_adr = '0, r_adr = '0;
    logic [31:0] w_dat = '0;
    logic [3:0]  w_sel = '0, r_sel = '0;

    always @(negedge clk) begin : slave32
        logic e;
        if (stb32) begin
            n_stb++;
            if (!we32) begin r_adr = adr32; r_sel = sel32; end
            if (scnt == (we32 ? s_wwr : s_wrd)) begin
                e      = we32 ? s_ewr : s_erd;
                serr32 = e;
                ack32  = e ? s_aerr : 1'b1;
                scnt   = 0;
                if (we32 && !e) begin
                    n_wr++; w_adr = adr32; w_dat = dat32; w_sel = sel32;
                end
            end else begin
                ack32 = 1'b0; serr32 = 1'b0; scnt++;
            end
        end else begin
            ack32 = 1'b0; serr32 = 1'b0; scnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Reference: each bus phase either completes after wait+1 strobe cycles or
    // is cut off after TO32 strobe cycles; an error ends the whole request.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        int   t = 1;
        logic ok = 1'b1;
        v.exp_rdata = prev; v.exp_wdat = '0; v.exp_sel = '0;
        v.exp_nwr = 0; v.exp_nstb = 0;
        if (v.ren) begin
            if (v.wrd < TO32) begin
                v.exp_nstb += v.wrd + 1; t += v.wrd + 1; ok = !v.erd;
            end else begin
                v.exp_nstb += TO32; t += TO32; ok = 1'b0;
            end
            if (ok) v.exp_rdata = v.srd;
        end
        if (ok && v.wen) begin
            if (v.ren) begin
                t += 1;
                v.exp_sel = 4'hF;
                for (int i = 0; i < 4; i++)
                    v.exp_wdat[8*i +: 8] = v.ws[i] ? v.wd[8*i +: 8] : v.srd[8*i +: 8];
            end else begin
                v.exp_wdat = v.wd; v.exp_sel = v.ws;
            end
            if (v.wwr < TO32) begin
                v.exp_nstb += v.wwr + 1; t += v.wwr + 1; ok = !v.ewr;
            end else begin
                v.exp_nstb += TO32; t += TO32; ok = 1'b0;
            end
            if (ok) v.exp_nwr = 1;
        end
        v.exp_done = t;
        v.exp_err  = !ok;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int   st0, wr0, dcyc, ndone;
        logic derr, gap, seen;
        s_wrd = v.wrd; s_wwr = v.wwr; s_erd = v.erd; s_ewr = v.ewr; s_aerr = v.aerr;
        sdat32 = v.srd;
        st0 = n_stb; wr0 = n_wr;
        @(negedge clk);
        ren32 = v.ren; wen32 = v.wen;
        hb_raddr = v.ra; hb_waddr = v.wa; hb_wdata = v.wd; hb_wstrb = v.ws;
        @(posedge clk);
        dcyc = -1; derr = 1'b0; gap = 1'b0; seen = 1'b0; ndone = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin ren32 = 1'b0; wen32 = 1'b0; end
            if (cyc32) seen = 1'b1;
            else if (seen && !done32 && dcyc < 0) gap = 1'b1;
            if (done32) begin
                ndone++;
                if (dcyc < 0) begin dcyc = n; derr = err32; end
            end
            if (dcyc > 0 && n >= dcyc + 2) break;
        end
        check({tag, ".done_cycle"}, 32'(dcyc), 32'(v.exp_done));
        check({tag, ".err"}, 32'(derr), 32'(v.exp_err));
        check({tag, ".done_pulses"}, 32'(ndone), 32'd1);
        check({tag, ".rdata"}, rdata32, v.exp_rdata);
        check({tag, ".writes"}, 32'(n_wr - wr0), 32'(v.exp_nwr));
        check({tag, ".strobe_cycles"}, 32'(n_stb - st0), 32'(v.exp_nstb));
        check({tag, ".cyc_gap"}, 32'(gap), 32'd0);
        if (v.exp_nwr == 1) begin
            check({tag, ".wdat"}, w_dat, v.exp_wdat);
            check({tag, ".wsel"}, 32'(w_sel), 32'(v.exp_sel));
            check({tag, ".wadr"}, 32'(w_adr), 32'(v.wa[7:0]));
        end
        if (v.ren) begin
            check({tag, ".radr"}, 32'(r_adr), 32'(v.ra[7:0]));
            check({tag, ".rsel"}, 32'(r_sel), 32'hF);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        tbl[9];
        vec_t        v;
        logic [31:0] model_rd;
        int          cnt, hold;

        //            ren  wen  ra      wa      wd            ws       srd           wrd wwr erd  ewr  aerr done err  rdata         wdat          sel      nwr nstb
        tbl[0] = '{1'b0,1'b1,32'h0,  32'h40, 32'hDEADBEEF,4'b0101,32'h0,        0,  0, 1'b0,1'b0,1'b0, 2,1'b0,32'h0,        32'hDEADBEEF,4'b0101, 1, 1};
        tbl[1] = '{1'b1,1'b1,32'h20, 32'h24, 32'hAABBCCDD,4'b0110,32'h11223344, 1,  2, 1'b0,1'b0,1'b0, 7,1'b0,32'h11223344, 32'h11BBCC44,4'hF,    1, 5};
        tbl[2] = '{1'b1,1'b1,32'h30, 32'h34, 32'h12345678,4'hF,   32'h55667788, 0,  0, 1'b1,1'b0,1'b0, 2,1'b1,32'h11223344, 32'h0,       4'h0,    0, 1};
        tbl[3] = '{1'b1,1'b0,32'h1FF,32'h0,  32'h0,       4'h0,   32'h99999999, 9,  0, 1'b0,1'b0,1'b0, 5,1'b1,32'h11223344, 32'h0,       4'h0,    0, 4};
        tbl[4] = '{1'b1,1'b0,32'h101,32'h0,  32'h0,       4'h0,   32'hCAFEF00D, 3,  0, 1'b0,1'b0,1'b0, 5,1'b0,32'hCAFEF00D, 32'h0,       4'h0,    0, 4};
        tbl[5] = '{1'b0,1'b1,32'h0,  32'h50, 32'h0,       4'h3,   32'h0,        0,  1, 1'b0,1'b1,1'b1, 3,1'b1,32'hCAFEF00D, 32'h0,       4'h0,    0, 2};
        tbl[6] = '{1'b1,1'b1,32'h60, 32'h64, 32'hFFFFFFFF,4'hF,   32'h01020304, 0,  7, 1'b0,1'b0,1'b0, 7,1'b1,32'h01020304, 32'h0,       4'h0,    0, 5};
        tbl[7] = '{1'b1,1'b0,32'h7,  32'h0,  32'h0,       4'h0,   32'h000000FF, 0,  0, 1'b0,1'b0,1'b0, 2,1'b0,32'h000000FF, 32'h0,       4'h0,    0, 1};
        tbl[8] = '{1'b1,1'b1,32'h10, 32'h10, 32'hAAAAAAAA,4'h0,   32'h87654321, 0,  0, 1'b0,1'b0,1'b0, 4,1'b0,32'h87654321, 32'h87654321,4'hF,    1, 2};

        repeat (2) @(posedge clk);
        #1;
        check("reset.bus32", {29'(0), cyc32, stb32, we32} | 32'(adr32) | dat32 | 32'(sel32), 32'h0);
        check("reset.hb32", rdata32 | 32'(done32) | 32'(err32), 32'h0);
        check("reset.bus8", {24'(0), dato8} | 32'({cyc8, stb8, we8, sel8}) | 32'(adr8), 32'h0);
        check("reset.hb8", rdata8 | 32'(done8) | 32'(err8), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 8-bit read: three wait states, then 0xA5.
        @(negedge clk);
        ren8 = 1'b1; hb_raddr = 32'h312;
        @(posedge clk);
        cnt = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) begin
                ren8 = 1'b0;
                check("t1.adr", 32'(adr8), 32'h12);
                check("t1.bus", 32'({cyc8, stb8, we8, sel8}), 32'b1101);
            end
            if (n < 5 && done8) cnt++;
            if (n == 4) begin sdat8 = 8'hA5; ack8 = 1'b1; end
            if (n == 5) begin
                ack8 = 1'b0;
                check("t1.done", 32'(done8), 32'd1);
                check("t1.err", 32'(err8), 32'd0);
                check("t1.rdata", rdata8, 32'h000000A5);
            end
        end
        check("t1.early_done", 32'(cnt), 32'd0);
        @(negedge clk);
        check("t1.single_pulse", 32'(done8), 32'd0);

        // Timeout disabled: strobe must hold until the slave finally answers.
        @(negedge clk);
        ren8 = 1'b1; hb_raddr = 32'h44;
        @(posedge clk);
        hold = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) ren8 = 1'b0;
            if (stb8 && !done8) hold++;
        end
        check("t5b.strobe_hold", 32'(hold), 32'd300);
        sdat8 = 8'h3C; ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
        check("t5b.done", 32'({done8, err8}), 32'b10);
        check("t5b.rdata", rdata8, 32'h3C);

        model_rd = '0;
        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
            model_rd = tbl[i].exp_rdata;
        end

        for (int i = 0; i < 40; i++) begin
            v = tbl[0];
            case ($urandom_range(0, 2))
                0:       begin v.ren = 1'b1; v.wen = 1'b0; end
                1:       begin v.ren = 1'b0; v.wen = 1'b1; end
                default: begin v.ren = 1'b1; v.wen = 1'b1; end
            endcase
            v.ra = $urandom; v.wa = $urandom; v.wd = $urandom; v.srd = $urandom;
            v.ws = 4'($urandom_range(0, 15));
            v.wrd = $urandom_range(0, 5); v.wwr = $urandom_range(0, 5);
            v.erd = ($urandom_range(0, 5) == 0);
            v.ewr = ($urandom_range(0, 5) == 0);
            v.aerr = 1'($urandom_range(0, 1));
            v = model(v, model_rd);
            run_vec(v, $sformatf("rnd%0d", i));
            model_rd = v.exp_rdata;
        end

        // Reset while a write is outstanding.
        s_wwr = 99; s_ewr = 1'b0;
        @(negedge clk);
        wen32 = 1'b1; hb_waddr = 32'h88; hb_wdata = 32'h5A5A5A5A; hb_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wen32 = 1'b0;
        check("t6.in_write", 32'({cyc32, stb32, we32}), 32'b111);
        #2 rst = 1'b1;
        #1;
        check("t6.bus_released", {29'(0), cyc32, stb32, we32} | 32'(adr32) | dat32 | 32'(sel32), 32'h0);
        check("t6.rdata_cleared", rdata32, 32'h0);
        cnt = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done32) cnt++;
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done32) cnt++;
        end
        check("t6.no_done", 32'(cnt), 32'd0);
        run_vec(tbl[1], "t6.after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
